wait_event_responder: RTL and testbench

Event-driven value sequencer: the responder end of the event/condition-wait handshake used by the dynamic-scheduler test designs. A requester pulses `ev_i` and then waits on a condition over `value_o`. The block answers each pulse by playing one burst of timed value updates from a small programmable script. It sits between a requester process model and any logic that polls or waits on the shared value.

---
 rtl/wait_event_responder.sv | 174 +++++++++++++++++
 tb/tb_wait_event_responder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wait_event_responder.sv
// wait_event_responder
// Responder side of an event/condition-wait handshake. Each event replays one
// burst of timed value assignments from a small programmable script; the
// script pointer persists across bursts, so consecutive events walk the script.
// Optional feature macro: WAIT_EVENT_QUEUE_EN
//   defined   : events arriving while busy are queued (2-bit, saturating at 3)
//   undefined : events arriving while busy are discarded
// In both builds a lost event sets the sticky ev_drop_o flag.
module wait_event_responder #(
    parameter int                 VALUE_W    = 32,
    parameter int                 DELAY_W    = 16,
    parameter int                 ADDR_W     = 3,
    parameter logic [VALUE_W-1:0] INIT_VALUE = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ev_i,
    input  logic               cfg_we,
    input  logic [ADDR_W-1:0]  cfg_addr,
    input  logic [VALUE_W-1:0] cfg_value,
    input  logic [DELAY_W-1:0] cfg_delay,
    input  logic               cfg_last,
    output logic [VALUE_W-1:0] value_o,
    output logic               value_upd_o,
    output logic               busy_o,
    output logic               burst_done_o,
    output logic [ADDR_W-1:0]  step_ptr_o,
    output logic               ev_drop_o
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COUNT  = 2'd2,
        ST_ASSIGN = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Script storage; deliberately not reset so a reset keeps the program.
    logic [VALUE_W-1:0] mem_value [0:DEPTH-1];
    logic [DELAY_W-1:0] mem_delay [0:DEPTH-1];
    logic               mem_last  [0:DEPTH-1];

    // Working copy of the active step, captured in LOAD.
    logic [VALUE_W-1:0] work_value;
    logic               work_last;
    logic [DELAY_W-1:0] count;

    logic [ADDR_W-1:0]  step_ptr;
    logic               drop_set;
    logic               chain_burst;

    // Script write port: writes land on any edge, whatever the state.
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            mem_value[cfg_addr] <= cfg_value;
            mem_delay[cfg_addr] <= cfg_delay;
            mem_last[cfg_addr]  <= cfg_last;
        end
    end

    // Registered script read in LOAD, then count down the step delay.
    // The raw delay is loaded; the COUNT exit test (count <= 1) makes a
    // delay of 0 behave exactly like a delay of 1. A write to the same entry
    // on the LOAD edge is not seen because the read samples the old contents.
    always_ff @(posedge clk) begin
        if (state == ST_LOAD) begin
            work_value <= mem_value[step_ptr];
            work_last  <= mem_last[step_ptr];
            count      <= mem_delay[step_ptr];
        end else if (state == ST_COUNT) begin
            count <= count - DELAY_W'(1);
        end
    end

`ifdef WAIT_EVENT_QUEUE_EN
    logic [1:0] pending;
    logic [1:0] pending_inc;
    logic [1:0] pending_next;
    logic       busy_ev;

    // Pending-event bookkeeping: count busy events (saturating), and consume
    // one at the end of a burst to start the next burst without idling.
    // An event in the final ASSIGN cycle is counted first, then consumed.
    always_comb begin
        busy_ev     = ev_i && (state != ST_IDLE);
        pending_inc = pending;
        drop_set    = 1'b0;
        if (busy_ev) begin
            if (pending == 2'd3) begin
                drop_set = 1'b1;
            end else begin
                pending_inc = pending + 2'd1;
            end
        end
        chain_burst  = (state == ST_ASSIGN) && work_last && (pending_inc != 2'd0);
        pending_next = chain_burst ? (pending_inc - 2'd1) : pending_inc;
    end

    // Pending counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 2'd0;
        end else begin
            pending <= pending_next;
        end
    end
`else
    // Without queuing, any event seen while busy is lost.
    always_comb begin
        drop_set    = ev_i && (state != ST_IDLE);
        chain_burst = 1'b0;
    end
`endif

    // Next-state logic for the burst sequencer.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (ev_i) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_next = ST_COUNT;
            end
            ST_COUNT: begin
                if (count <= DELAY_W'(1)) begin
                    state_next = ST_ASSIGN;
                end
            end
            ST_ASSIGN: begin
                if (!work_last || chain_burst) begin
                    state_next = ST_LOAD;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register plus the registered outputs updated on ASSIGN edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            step_ptr     <= '0;
            value_o      <= INIT_VALUE;
            value_upd_o  <= 1'b0;
            burst_done_o <= 1'b0;
            ev_drop_o    <= 1'b0;
        end else begin
            state        <= state_next;
            value_upd_o  <= (state == ST_ASSIGN);
            burst_done_o <= (state == ST_ASSIGN) && work_last;
            ev_drop_o    <= ev_drop_o | drop_set;
            if (state == ST_ASSIGN) begin
                value_o  <= work_value;
                step_ptr <= step_ptr + ADDR_W'(1);
            end
        end
    end

    assign busy_o     = (state != ST_IDLE);
    assign step_ptr_o = step_ptr;

endmodule

// File: tb/tb_wait_event_responder.sv
// Testbench for wait_event_responder.
// A reference model turns each sampled event into the list of expected
// assignments (edge number, value, burst-done flag, pointer afterwards) using
// the latency rules directly; a monitor pops and compares on value_upd_o.
module tb_wait_event_responder;

    localparam int          VALUE_W = 32;
    localparam int          DELAY_W = 16;
    localparam int          ADDR_W  = 3;
    localparam int          DEPTH   = 8;
    localparam logic [31:0] INIT_V  = 32'h5A5A_0001;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               ev_i = 1'b0;
    logic               cfg_we = 1'b0;
    logic [ADDR_W-1:0]  cfg_addr = '0;
    logic [VALUE_W-1:0] cfg_value = '0;
    logic [DELAY_W-1:0] cfg_delay = '0;
    logic               cfg_last = 1'b0;
    logic [VALUE_W-1:0] value_o;
    logic               value_upd_o;
    logic               busy_o;
    logic               burst_done_o;
    logic [ADDR_W-1:0]  step_ptr_o;
    logic               ev_drop_o;

    wait_event_responder #(
        .VALUE_W    (VALUE_W),
        .DELAY_W    (DELAY_W),
        .ADDR_W     (ADDR_W),
        .INIT_VALUE (INIT_V)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ev_i         (ev_i),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_value    (cfg_value),
        .cfg_delay    (cfg_delay),
        .cfg_last     (cfg_last),
        .value_o      (value_o),
        .value_upd_o  (value_upd_o),
        .busy_o       (busy_o),
        .burst_done_o (burst_done_o),
        .step_ptr_o   (step_ptr_o),
        .ev_drop_o    (ev_drop_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          t;
        logic [31:0] v;
        logic        done;
        logic [2:0]  p;
    } exp_t;

    exp_t        q[$];
    int          compared = 0;
    int          mismatched = 0;
    int          n = 0;
    int          busy_until = -1;
    int          m_pend = 0;
    bit          m_drop = 0;
    int          m_ptr = 0;
    logic [31:0] m_val [DEPTH];
    int          m_del [DEPTH];
    bit          m_last [DEPTH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            if (mismatched <= 40)
                $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, n);
        end
    endtask

    // Expand one burst starting with LOAD after edge s into expected assignments.
    task automatic start_burst(input int s);
        int t;
        int steps;
        bit fin;
        t = s;
        steps = 0;
        fin = 0;
        while (!fin && steps < 64) begin
            int   d;
            exp_t e;
            d = (m_del[m_ptr] == 0) ? 1 : m_del[m_ptr];
            t = t + d + 2;
            e.t = t;
            e.v = m_val[m_ptr];
            e.done = m_last[m_ptr];
            e.p = 3'((m_ptr + 1) % DEPTH);
            q.push_back(e);
            fin = m_last[m_ptr];
            m_ptr = (m_ptr + 1) % DEPTH;
            steps++;
        end
        busy_until = t;
    endtask

    // Reference model: advances on each rising edge.
    always @(posedge clk) begin
        n++;
        if (!rst) begin
            if (cfg_we) begin
                m_val[cfg_addr]  = cfg_value;
                m_del[cfg_addr]  = int'(cfg_delay);
                m_last[cfg_addr] = cfg_last;
            end
            if (ev_i) begin
                if (n <= busy_until) begin
`ifdef WAIT_EVENT_QUEUE_EN
                    if (m_pend == 3) m_drop = 1;
                    else m_pend++;
`else
                    m_drop = 1;
`endif
                end else begin
                    start_burst(n);
                end
            end
            if (m_pend > 0 && busy_until == n) begin
                m_pend--;
                start_burst(n);
            end
        end
    end

    // Monitor: sample away from the active edge and score each assignment.
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", 64'(busy_o), 64'(n < busy_until));
            chk("ev_drop", 64'(ev_drop_o), 64'(m_drop));
            if (value_upd_o) begin
                $display("upd edge=%0d value=%h done=%0d ptr=%0d", n, value_o, burst_done_o, step_ptr_o);
                if (q.size() == 0) begin
                    chk("unexpected_upd", 64'(value_upd_o), 64'(0));
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("upd_edge", 64'(n), 64'(e.t));
                    chk("value", 64'(value_o), 64'(e.v));
                    chk("burst_done", 64'(burst_done_o), 64'(e.done));
                    chk("step_ptr", 64'(step_ptr_o), 64'(e.p));
                end
            end else begin
                chk("done_without_upd", 64'(burst_done_o), 64'(0));
                if (q.size() > 0 && q[0].t <= n) begin
                    chk("upd_present", 64'(value_upd_o), 64'(1));
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic wr(input int a, input logic [31:0] v, input int d, input bit l);
        @(negedge clk);
        cfg_we = 1'b1;
        cfg_addr = 3'(a);
        cfg_value = v;
        cfg_delay = 16'(d);
        cfg_last = l;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic pulse();
        @(negedge clk);
        ev_i = 1'b1;
        @(negedge clk);
        ev_i = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (n >= busy_until && m_pend == 0 && q.size() == 0) break;
        end
        chk("idle_wait_bounded", 64'(k < 3000), 64'(1));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        m_pend = 0;
        m_drop = 0;
        m_ptr = 0;
        busy_until = n;
        #1;
        chk("rst_value", 64'(value_o), 64'(INIT_V));
        chk("rst_step_ptr", 64'(step_ptr_o), 64'(0));
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_value_upd", 64'(value_upd_o), 64'(0));
        chk("rst_burst_done", 64'(burst_done_o), 64'(0));
        chk("rst_ev_drop", 64'(ev_drop_o), 64'(0));
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wv [DEPTH];
        bit          exp_drop;

`ifdef WAIT_EVENT_QUEUE_EN
        exp_drop = 0;
`else
        exp_drop = 1;
`endif
        repeat (2) @(negedge clk);
        chk("init_value", 64'(value_o), 64'(INIT_V));
        chk("init_step_ptr", 64'(step_ptr_o), 64'(0));
        chk("init_busy", 64'(busy_o), 64'(0));
        chk("init_ev_drop", 64'(ev_drop_o), 64'(0));
        rst = 1'b0;

        // Reference script plus delay-0 / delay-1 entries.
        wr(0, 32'd1, 10, 0);
        wr(1, 32'd2, 10, 1);
        wr(2, 32'd0, 10, 1);
        wr(3, 32'd2, 10, 1);
        wr(4, 32'h44, 0, 1);
        wr(5, 32'h55, 1, 1);
        wr(6, 32'h66, 2, 1);
        wr(7, 32'h77, 0, 1);
        pulse(); wait_idle();
        chk("ref_value_a", 64'(value_o), 64'(2));
        pulse(); wait_idle();
        chk("ref_value_b", 64'(value_o), 64'(0));
        pulse(); wait_idle();
        chk("ref_value_c", 64'(value_o), 64'(2));
        chk("ref_step_ptr", 64'(step_ptr_o), 64'(4));
        pulse(); wait_idle();
        pulse(); wait_idle();
        chk("delay1_value", 64'(value_o), 64'(32'h55));

        // Wrap-around: every entry ends a burst, nine events.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            wv[i] = $urandom;
            wr(i, wv[i], $urandom_range(0, 3), 1);
        end
        for (int i = 0; i < 9; i++) begin
            pulse(); wait_idle();
        end
        chk("wrap_step_ptr", 64'(step_ptr_o), 64'(1));
        chk("wrap_replay", 64'(value_o), 64'(wv[0]));

        // Two-step bursts; extra events arrive while busy.
        for (int i = 0; i < DEPTH; i++) wr(i, 32'h100 + 32'(i), 3, (i % 2) == 1);
        do_reset();
        pulse(); pulse(); pulse();
        wait_idle();
        chk("busy2_ev_drop", 64'(ev_drop_o), 64'(exp_drop));
        do_reset();
        pulse(); pulse(); pulse(); pulse(); pulse();
        wait_idle();
        chk("sat_ev_drop", 64'(ev_drop_o), 64'(1));

        // Reset during the delay of entry 1; the script must survive.
        wr(0, 32'hA0, 2, 0);
        wr(1, 32'hA1, 20, 1);
        do_reset();
        pulse();
        repeat (10) @(negedge clk);
        do_reset();
        pulse(); wait_idle();
        chk("post_reset_replay", 64'(value_o), 64'(32'hA1));
        chk("post_reset_ptr", 64'(step_ptr_o), 64'(2));

        // Randomized traffic with periodic reprogramming while idle.
        do_reset();
        for (int blk = 0; blk < 6; blk++) begin
            wait_idle();
            for (int i = 0; i < DEPTH; i++)
                wr(i, $urandom, $urandom_range(0, 6), (i == DEPTH - 1) || ($urandom_range(0, 2) == 0));
            for (int c = 0; c < 250; c++) begin
                @(negedge clk);
                ev_i = ($urandom_range(0, 99) < 8);
            end
            @(negedge clk);
            ev_i = 1'b0;
        end
        wait_idle();
        chk("queue_drained", 64'(q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
